// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the RV32I execute stage.
// Holds the selector encodings driven by decode and the hazard unit, the
// func_3 codes used by the ALU and the branch comparator, and the packed
// EX/MEM bundle that ex_stage registers for the memory stage.
package ex_pkg;

   localparam int DATA_W = 32;

   // ALU operand A source.
   typedef enum logic [1:0] {
      OPA_RS1      = 2'b00,
      OPA_PC       = 2'b01,
      OPA_ZERO     = 2'b10,
      OPA_ZERO_ALT = 2'b11
   } opa_sel_e;

   // Next-PC source.
   typedef enum logic [1:0] {
      NPC_SEQ    = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JAL    = 2'b10,
      NPC_JALR   = 2'b11
   } npc_sel_e;

   // ALU operation class.
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_RTYPE = 2'b01,
      ALU_ITYPE = 2'b10,
      ALU_CMP   = 2'b11
   } alu_op_e;

   // Operand forwarding source; the reserved code behaves like FWD_ID_EX.
   typedef enum logic [1:0] {
      FWD_ID_EX = 2'b00,
      FWD_MEM   = 2'b01,
      FWD_WB    = 2'b10,
      FWD_RSVD  = 2'b11
   } fwd_sel_e;

   // func_3 codes for arithmetic/logic operations.
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // func_3 codes for branch compares.
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // EX/MEM pipeline register contents.
   typedef struct packed {
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] rs2_data;
      logic [4:0]        rd;
      logic [2:0]        func_3;
      logic              im_to_rf;
      logic              store;
      logic              load;
      logic              valid;
   } ex_mem_t;

   // Jumps write the link value instead of the ALU result.
   function automatic logic is_jump(input npc_sel_e sel);
      return (sel == NPC_JAL) || (sel == NPC_JALR);
   endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I ALU plus branch comparator.
// Ports:
//   a, b          operands (already forwarded / selected)
//   op            operation class (add, R-type, I-type, compare)
//   func_3        operation / compare code
//   func_7_bit_6  SUB/SRA select (R-type) or SRAI select (I-type)
//   result        ALU result; for compare ops the zero-extended compare bit
//   cmp           branch condition per func_3, independent of op
module alu_core
   import ex_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_e           op,
   input  logic [2:0]        func_3,
   input  logic              func_7_bit_6,
   output logic [DATA_W-1:0] result,
   output logic              cmp
);

   logic [4:0]               shamt;
   logic                     eq;
   logic                     lt_s;
   logic                     lt_u;
   logic                     alt;
   logic signed [DATA_W-1:0] sra_res;

   assign shamt   = b[4:0];
   assign eq      = (a == b);
   assign lt_s    = $signed(a) < $signed(b);
   assign lt_u    = a < b;
   // Kept as a separate signed net so the arithmetic shift is not turned
   // into a logical one by mixing with unsigned operands in a ?: expression.
   assign sra_res = $signed(a) >>> shamt;

   always_comb begin
      cmp = 1'b0;
      case (func_3)
         F3_BEQ:  cmp = eq;
         F3_BNE:  cmp = ~eq;
         F3_BLT:  cmp = lt_s;
         F3_BGE:  cmp = ~lt_s;
         F3_BLTU: cmp = lt_u;
         F3_BGEU: cmp = ~lt_u;
         default: cmp = 1'b0;
      endcase
   end

   // I-type only honours bit 6 for SRAI so ADDI can never subtract.
   always_comb begin
      alt = 1'b0;
      if (op == ALU_RTYPE) begin
         alt = func_7_bit_6;
      end else if (op == ALU_ITYPE) begin
         alt = func_7_bit_6 & (func_3 == F3_SR);
      end
   end

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_RTYPE, ALU_ITYPE: begin
            case (func_3)
               F3_ADD:  result = alt ? (a - b) : (a + b);
               F3_SLL:  result = a << shamt;
               F3_SLT:  result = {{(DATA_W-1){1'b0}}, lt_s};
               F3_SLTU: result = {{(DATA_W-1){1'b0}}, lt_u};
               F3_XOR:  result = a ^ b;
               F3_SR:   result = alt ? sra_res : (a >> shamt);
               F3_OR:   result = a | b;
               F3_AND:  result = a & b;
               default: result = '0;
            endcase
         end
         ALU_CMP: result = {{(DATA_W-1){1'b0}}, cmp};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32I 5-stage pipeline.
// Forwards rs1/rs2, runs the ALU and branch comparator, computes the
// branch/jump target, raises a single-shot PC redirect and registers the
// results into the EX/MEM register (with stall and flush).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   valid_ex, stall, flush       slot valid and hazard-unit controls
//   forward_a_sel/forward_b_sel  operand forwarding selects
//   wb_data                      write-back result for forwarding
//   pc_ex, pc_plus_4_ex, rd_ex, func_3_ex, func_7_bit_6_ex, control bits,
//   selectors, rs1/rs2 data and immediates from the ID/EX register
//   *_mem                        registered EX/MEM outputs
//   redirect, redirect_pc, misaligned  combinational PC redirect
module ex_stage
   import ex_pkg::*;
#(
   parameter int          XLEN          = 32,
   parameter logic [31:0] RESET_PC_MASK = 32'hFFFF_FFFE
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_ex,
   input  logic            stall,
   input  logic            flush,
   input  logic [1:0]      forward_a_sel,
   input  logic [1:0]      forward_b_sel,
   input  logic [XLEN-1:0] wb_data,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] pc_plus_4_ex,
   input  logic [4:0]      rd_ex,
   input  logic [2:0]      func_3_ex,
   input  logic            func_7_bit_6_ex,
   input  logic            im_to_rf_ex,
   input  logic            store_ex,
   input  logic            load_ex,
   input  logic            branch_ex,
   input  logic [1:0]      alu_operand_a_selector_ex,
   input  logic            alu_operand_b_selector_ex,
   input  logic [1:0]      next_pc_selector_ex,
   input  logic [1:0]      alu_operations_selector_ex,
   input  logic [XLEN-1:0] rs1_data_ex,
   input  logic [XLEN-1:0] rs2_data_ex,
   input  logic [XLEN-1:0] i_type_ex,
   input  logic [XLEN-1:0] sb_type_ex,
   input  logic [XLEN-1:0] uj_type_ex,
   input  logic [XLEN-1:0] immediate_ex,
   output logic [XLEN-1:0] alu_result_mem,
   output logic [XLEN-1:0] rs2_data_mem,
   output logic [4:0]      rd_mem,
   output logic [2:0]      func_3_mem,
   output logic            im_to_rf_mem,
   output logic            store_mem,
   output logic            load_mem,
   output logic            valid_mem,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            misaligned
);

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DONE = 1'b1
   } rd_state_e;

   rd_state_e       state_reg;
   rd_state_e       state_next;
   ex_mem_t         ex_mem_reg;
   ex_mem_t         ex_mem_next;

   npc_sel_e        npc_sel;
   logic [1:0]      fwd_sel_arr [2];
   logic [XLEN-1:0] id_ex_arr   [2];
   logic [XLEN-1:0] fwd_arr     [2];
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_out;
   logic            cmp;
   logic            taken;
   logic [XLEN-1:0] target;

   assign npc_sel = npc_sel_e'(next_pc_selector_ex);

   // Operand forwarding: index 0 is rs1, index 1 is rs2. The MEM source is
   // this stage's own EX/MEM register.
   assign fwd_sel_arr[0] = forward_a_sel;
   assign fwd_sel_arr[1] = forward_b_sel;
   assign id_ex_arr[0]   = rs1_data_ex;
   assign id_ex_arr[1]   = rs2_data_ex;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_arr[gi] = (fwd_sel_arr[gi] == FWD_MEM) ? ex_mem_reg.alu_result :
                           (fwd_sel_arr[gi] == FWD_WB)  ? wb_data :
                                                          id_ex_arr[gi];
   end

   always_comb begin
      op_a = '0;
      case (opa_sel_e'(alu_operand_a_selector_ex))
         OPA_RS1: op_a = fwd_arr[0];
         OPA_PC:  op_a = pc_ex;
         default: op_a = '0;
      endcase
   end

   assign op_b = alu_operand_b_selector_ex ? immediate_ex : fwd_arr[1];

   alu_core u_alu (
      .a            (op_a),
      .b            (op_b),
      .op           (alu_op_e'(alu_operations_selector_ex)),
      .func_3       (func_3_ex),
      .func_7_bit_6 (func_7_bit_6_ex),
      .result       (alu_out),
      .cmp          (cmp)
   );

   // Target and taken decision; all sums wrap naturally at XLEN bits.
   always_comb begin
      taken  = 1'b0;
      target = pc_plus_4_ex;
      case (npc_sel)
         NPC_BRANCH: begin
            taken  = branch_ex & cmp;
            target = pc_ex + sb_type_ex;
         end
         NPC_JAL: begin
            taken  = 1'b1;
            target = pc_ex + uj_type_ex;
         end
         NPC_JALR: begin
            taken  = 1'b1;
            target = (fwd_arr[0] + i_type_ex) & RESET_PC_MASK;
         end
         default: begin
            taken  = 1'b0;
            target = pc_plus_4_ex;
         end
      endcase
   end

   // Once a redirect has been issued for a stalled instruction, RD_DONE
   // suppresses it until the instruction leaves EX.
   assign redirect    = valid_ex & taken & (state_reg == RD_IDLE) & ~rst;
   assign redirect_pc = target;
   assign misaligned  = redirect & target[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RD_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = RD_IDLE;
      end else begin
         case (state_reg)
            RD_IDLE: if (redirect && stall) state_next = RD_DONE;
            RD_DONE: if (!stall)            state_next = RD_IDLE;
            default: state_next = RD_IDLE;
         endcase
      end
   end

   // EX/MEM register: flush beats stall; an invalid slot becomes a bubble.
   always_comb begin
      ex_mem_next = ex_mem_reg;
      if (flush || (!stall && !valid_ex)) begin
         ex_mem_next = '0;
      end else if (!stall) begin
         ex_mem_next.alu_result = is_jump(npc_sel) ? pc_plus_4_ex : alu_out;
         ex_mem_next.rs2_data   = fwd_arr[1];
         ex_mem_next.rd         = rd_ex;
         ex_mem_next.func_3     = func_3_ex;
         ex_mem_next.im_to_rf   = im_to_rf_ex;
         ex_mem_next.store      = store_ex;
         ex_mem_next.load       = load_ex;
         ex_mem_next.valid      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem_reg <= '0;
      end else begin
         ex_mem_reg <= ex_mem_next;
      end
   end

   assign alu_result_mem = ex_mem_reg.alu_result;
   assign rs2_data_mem   = ex_mem_reg.rs2_data;
   assign rd_mem         = ex_mem_reg.rd;
   assign func_3_mem     = ex_mem_reg.func_3;
   assign im_to_rf_mem   = ex_mem_reg.im_to_rf;
   assign store_mem      = ex_mem_reg.store;
   assign load_mem       = ex_mem_reg.load;
   assign valid_mem      = ex_mem_reg.valid;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with a behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_ex_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid_ex, stall, flush;
   logic [1:0]  forward_a_sel, forward_b_sel;
   logic [31:0] wb_data, pc_ex, pc_plus_4_ex;
   logic [4:0]  rd_ex;
   logic [2:0]  func_3_ex;
   logic        func_7_bit_6_ex;
   logic        im_to_rf_ex, store_ex, load_ex, branch_ex;
   logic [1:0]  alu_operand_a_selector_ex;
   logic        alu_operand_b_selector_ex;
   logic [1:0]  next_pc_selector_ex, alu_operations_selector_ex;
   logic [31:0] rs1_data_ex, rs2_data_ex, i_type_ex, sb_type_ex, uj_type_ex, immediate_ex;

   logic [31:0] alu_result_mem, rs2_data_mem;
   logic [4:0]  rd_mem;
   logic [2:0]  func_3_mem;
   logic        im_to_rf_mem, store_mem, load_mem, valid_mem;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        misaligned;

   ex_stage dut (
      .clk(clk), .rst(rst), .valid_ex(valid_ex), .stall(stall), .flush(flush),
      .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
      .wb_data(wb_data), .pc_ex(pc_ex), .pc_plus_4_ex(pc_plus_4_ex),
      .rd_ex(rd_ex), .func_3_ex(func_3_ex), .func_7_bit_6_ex(func_7_bit_6_ex),
      .im_to_rf_ex(im_to_rf_ex), .store_ex(store_ex), .load_ex(load_ex),
      .branch_ex(branch_ex),
      .alu_operand_a_selector_ex(alu_operand_a_selector_ex),
      .alu_operand_b_selector_ex(alu_operand_b_selector_ex),
      .next_pc_selector_ex(next_pc_selector_ex),
      .alu_operations_selector_ex(alu_operations_selector_ex),
      .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
      .i_type_ex(i_type_ex), .sb_type_ex(sb_type_ex), .uj_type_ex(uj_type_ex),
      .immediate_ex(immediate_ex),
      .alu_result_mem(alu_result_mem), .rs2_data_mem(rs2_data_mem),
      .rd_mem(rd_mem), .func_3_mem(func_3_mem), .im_to_rf_mem(im_to_rf_mem),
      .store_mem(store_mem), .load_mem(load_mem), .valid_mem(valid_mem),
      .redirect(redirect), .redirect_pc(redirect_pc), .misaligned(misaligned)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit checking = 1'b0;

   // Model of what the MEM stage should be holding, and whether the
   // instruction currently in EX has already redirected.
   logic [31:0] m_alu, m_st;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   logic        m_wr, m_store, m_load, m_valid;
   bit          m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] own);
      if (s == 2'd1) return m_alu;
      if (s == 2'd2) return wb_data;
      return own;
   endfunction

   // What EX must produce right now from the architectural rules.
   task automatic model_now(output logic red, output logic [31:0] tgt,
                            output logic [31:0] res, output logic [31:0] sdata);
      logic [31:0] rs1v, rs2v, a, b;
      logic        c, tk;
      int          sh;
      rs1v  = pick(forward_a_sel, rs1_data_ex);
      rs2v  = pick(forward_b_sel, rs2_data_ex);
      a     = (alu_operand_a_selector_ex == 2'd0) ? rs1v :
              (alu_operand_a_selector_ex == 2'd1) ? pc_ex : 32'd0;
      b     = alu_operand_b_selector_ex ? immediate_ex : rs2v;
      sh    = int'(b % 32);
      sdata = rs2v;
      case (func_3_ex)
         3'd0: c = (a == b);
         3'd1: c = (a != b);
         3'd4: c = ($signed(a) < $signed(b));
         3'd5: c = ($signed(a) >= $signed(b));
         3'd6: c = (a < b);
         3'd7: c = (a >= b);
         default: c = 1'b0;
      endcase
      res = 32'd0;
      if (alu_operations_selector_ex == 2'd0) res = a + b;
      else if (alu_operations_selector_ex == 2'd3) res = {31'd0, c};
      else begin
         case (func_3_ex)
            3'd0: begin
               if (alu_operations_selector_ex == 2'd1 && func_7_bit_6_ex) res = a - b;
               else res = a + b;
            end
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: begin
               if (func_7_bit_6_ex) res = 32'($signed(a) >>> sh);
               else res = a >> sh;
            end
            3'd6: res = a | b;
            default: res = a & b;
         endcase
      end
      tk  = 1'b0;
      tgt = 32'd0;
      case (next_pc_selector_ex)
         2'd1: begin tk = branch_ex && c; tgt = pc_ex + sb_type_ex; end
         2'd2: begin tk = 1'b1; tgt = pc_ex + uj_type_ex; res = pc_plus_4_ex; end
         2'd3: begin tk = 1'b1; tgt = (rs1v + i_type_ex) & 32'hFFFF_FFFE; res = pc_plus_4_ex; end
         default: ;
      endcase
      red = valid_ex && tk && !m_done && !rst;
   endtask

   logic        u_red;
   logic [31:0] u_tgt, u_res, u_sd;
   always @(posedge clk) begin
      model_now(u_red, u_tgt, u_res, u_sd);
      if (rst) begin
         {m_alu, m_st, m_rd, m_f3, m_wr, m_store, m_load, m_valid} = '0;
         m_done = 1'b0;
      end else begin
         // A redirect already issued stays suppressed while the instruction is stuck.
         if (flush) m_done = 1'b0;
         else if (stall) m_done = m_done || u_red;
         else m_done = 1'b0;
         if (flush || (!stall && !valid_ex)) begin
            {m_alu, m_st, m_rd, m_f3, m_wr, m_store, m_load, m_valid} = '0;
         end else if (!stall) begin
            m_alu = u_res; m_st = u_sd; m_rd = rd_ex; m_f3 = func_3_ex;
            m_wr = im_to_rf_ex; m_store = store_ex; m_load = load_ex; m_valid = 1'b1;
         end
      end
   end

   logic        c_red;
   logic [31:0] c_tgt, c_res, c_sd;
   always @(negedge clk) begin
      if (checking) begin
         model_now(c_red, c_tgt, c_res, c_sd);
         check("redirect", {31'd0, redirect}, {31'd0, c_red});
         if (c_red) check("redirect_pc", redirect_pc, c_tgt);
         check("misaligned", {31'd0, misaligned}, {31'd0, c_red & c_tgt[1]});
         check("alu_result_mem", alu_result_mem, m_alu);
         check("rs2_data_mem", rs2_data_mem, m_st);
         check("rd_mem", {27'd0, rd_mem}, {27'd0, m_rd});
         check("func_3_mem", {29'd0, func_3_mem}, {29'd0, m_f3});
         check("ctrl_mem", {28'd0, im_to_rf_mem, store_mem, load_mem, valid_mem},
               {28'd0, m_wr, m_store, m_load, m_valid});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_ex = 0; stall = 0; flush = 0;
      forward_a_sel = 0; forward_b_sel = 0; wb_data = 0;
      pc_ex = 0; pc_plus_4_ex = 4; rd_ex = 0; func_3_ex = 0; func_7_bit_6_ex = 0;
      im_to_rf_ex = 0; store_ex = 0; load_ex = 0; branch_ex = 0;
      alu_operand_a_selector_ex = 0; alu_operand_b_selector_ex = 0;
      next_pc_selector_ex = 0; alu_operations_selector_ex = 0;
      rs1_data_ex = 0; rs2_data_ex = 0; i_type_ex = 0; sb_type_ex = 0;
      uj_type_ex = 0; immediate_ex = 0;
   endtask

   task automatic set_alu(input logic [1:0] op, input logic [2:0] f3, input logic b6,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic opb, input logic [31:0] imm);
      valid_ex = 1; alu_operations_selector_ex = op; func_3_ex = f3; func_7_bit_6_ex = b6;
      rs1_data_ex = rs1; rs2_data_ex = rs2; alu_operand_b_selector_ex = opb;
      immediate_ex = imm; alu_operand_a_selector_ex = 0; next_pc_selector_ex = 0;
      im_to_rf_ex = 1; branch_ex = 0; store_ex = 0; load_ex = 0;
      forward_a_sel = 0; forward_b_sel = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick();
      checking = 1'b1;
      tick();
      check("reset_alu", alu_result_mem, 32'd0);
      check("reset_valid", {31'd0, valid_mem}, 32'd0);
      rst = 0;

      // ADD / SUB / ADDI
      set_alu(2'd1, 3'd0, 1'b0, 32'd7, 32'd3, 1'b0, 32'd0); rd_ex = 5;
      tick();
      check("add", alu_result_mem, 32'd10);
      check("add_rd", {27'd0, rd_mem}, 32'd5);
      check("add_valid", {31'd0, valid_mem}, 32'd1);
      func_7_bit_6_ex = 1;
      tick();
      check("sub", alu_result_mem, 32'd4);
      set_alu(2'd2, 3'd0, 1'b1, 32'd7, 32'd99, 1'b1, 32'd3);
      tick();
      check("addi_bit6", alu_result_mem, 32'd10);

      // Shifts and set-less-than
      set_alu(2'd1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 1'b0, 32'd0);
      tick();
      check("sra", alu_result_mem, 32'hF800_0000);
      set_alu(2'd2, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 1'b1, 32'd4);
      tick();
      check("srli", alu_result_mem, 32'h0800_0000);
      set_alu(2'd1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
      tick();
      check("slt", alu_result_mem, 32'd1);
      func_3_ex = 3'd3;
      tick();
      check("sltu", alu_result_mem, 32'd0);

      // Forwarding: prime MEM with 0x100, then forward MEM to A and WB to B
      set_alu(2'd2, 3'd0, 1'b0, 32'h100, 32'd0, 1'b1, 32'd0);
      tick();
      set_alu(2'd0, 3'd2, 1'b0, 32'h999, 32'h777, 1'b0, 32'd0);
      forward_a_sel = 2'd1; forward_b_sel = 2'd2; wb_data = 32'd5;
      store_ex = 1; im_to_rf_ex = 0;
      tick();
      check("fwd_add", alu_result_mem, 32'h105);
      check("fwd_store_data", rs2_data_mem, 32'd5);
      check("fwd_store", {31'd0, store_mem}, 32'd1);

      // BLT signed taken, BLTU not taken
      set_alu(2'd3, 3'd4, 1'b0, 32'd0, 32'd1, 1'b0, 32'd0);
      forward_a_sel = 2'd2; wb_data = 32'hFFFF_FFFF;
      pc_ex = 32'h40; pc_plus_4_ex = 32'h44; sb_type_ex = 32'h10;
      next_pc_selector_ex = 2'd1; branch_ex = 1; im_to_rf_ex = 0;
      #1;
      check("blt_redirect", {31'd0, redirect}, 32'd1);
      check("blt_target", redirect_pc, 32'h50);
      func_3_ex = 3'd6;
      #1;
      check("bltu_redirect", {31'd0, redirect}, 32'd0);
      tick();

      // JALR to an odd, 2-misaligned address
      set_alu(2'd0, 3'd0, 1'b0, 32'h1003, 32'd0, 1'b0, 32'd0);
      next_pc_selector_ex = 2'd3; i_type_ex = 32'd0;
      pc_ex = 32'h80; pc_plus_4_ex = 32'h84; rd_ex = 1;
      #1;
      check("jalr_target", redirect_pc, 32'h1002);
      check("jalr_misaligned", {31'd0, misaligned}, 32'd1);
      tick();
      check("jalr_link", alu_result_mem, 32'h84);

      // Taken BEQ held by a 3-cycle stall: one redirect pulse only
      set_alu(2'd3, 3'd0, 1'b0, 32'd9, 32'd9, 1'b0, 32'd0);
      next_pc_selector_ex = 2'd1; branch_ex = 1; im_to_rf_ex = 0;
      pc_ex = 32'h200; pc_plus_4_ex = 32'h204; sb_type_ex = 32'h20;
      stall = 1;
      #1;
      check("stall_first_redirect", {31'd0, redirect}, 32'd1);
      check("stall_first_target", redirect_pc, 32'h220);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_no_redirect", {31'd0, redirect}, 32'd0);
         check("stall_hold", alu_result_mem, 32'h84);
      end
      stall = 0;
      #1;
      check("release_no_redirect", {31'd0, redirect}, 32'd0);
      tick();
      check("release_valid", {31'd0, valid_mem}, 32'd1);
      pc_ex = 32'h300; sb_type_ex = 32'hFFFF_FFFC;
      #1;
      check("new_branch_redirect", {31'd0, redirect}, 32'd1);
      check("new_branch_target", redirect_pc, 32'h2FC);
      tick();

      // Reset in the middle of a stalled JAL
      set_alu(2'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      next_pc_selector_ex = 2'd2; pc_ex = 32'h400; pc_plus_4_ex = 32'h404;
      uj_type_ex = 32'h100; rd_ex = 1; stall = 1;
      #1;
      check("jal_target", redirect_pc, 32'h500);
      tick();
      check("jal_stalled_no_redirect", {31'd0, redirect}, 32'd0);
      rst = 1;
      #1;
      check("reset_no_redirect", {31'd0, redirect}, 32'd0);
      tick();
      check("midreset_valid", {31'd0, valid_mem}, 32'd0);
      check("midreset_alu", alu_result_mem, 32'd0);
      rst = 0;
      #1;
      check("post_reset_redirect", {31'd0, redirect}, 32'd1);
      stall = 0;
      tick();
      check("jal_link", alu_result_mem, 32'h404);

      // Flush together with stall, with a redirect in the same cycle
      set_alu(2'd1, 3'd0, 1'b0, 32'd1, 32'd2, 1'b0, 32'd0);
      tick();
      check("pre_flush", alu_result_mem, 32'd3);
      next_pc_selector_ex = 2'd2; pc_ex = 32'h10; uj_type_ex = 32'h2;
      flush = 1; stall = 1;
      #1;
      check("flush_redirect", {31'd0, redirect}, 32'd1);
      check("flush_misaligned", {31'd0, misaligned}, 32'd1);
      tick();
      check("flush_valid", {31'd0, valid_mem}, 32'd0);
      check("flush_alu", alu_result_mem, 32'd0);
      flush = 0; stall = 0;

      // Invalid slot registers a bubble and never redirects
      set_alu(2'd1, 3'd0, 1'b0, 32'd1, 32'd2, 1'b0, 32'd0);
      next_pc_selector_ex = 2'd2; valid_ex = 0;
      #1;
      check("bubble_no_redirect", {31'd0, redirect}, 32'd0);
      tick();
      check("bubble_valid", {31'd0, valid_mem}, 32'd0);
      check("bubble_ctrl", {31'd0, im_to_rf_mem}, 32'd0);

      idle_inputs();
      tick();
      tick();
      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline and the consumer of every field the ID/EX register produces.
- Applies forwarding to the operands and computes the ALU result, branch decision and jump/branch target.
- Raises a single-shot PC redirect and registers the results into an internal EX/MEM register that has stall and flush control.
- Sits between id_ex and the memory stage; its stall/flush/forward selects are driven by the hazard unit.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC_MASK, 32'hFFFF_FFFE, mask applied to JALR targets (clears bit 0).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_ex  in  1  EX slot holds a real instruction
stall  in  1  hold the EX/MEM register and the redirect-done flag
flush  in  1  load a bubble into EX/MEM
forward_a_sel / forward_b_sel  in  2 each  00 id_ex data, 01 alu_result_mem, 10 wb_data, 11 reserved (treated as 00)
wb_data  in  32  write-back stage result
pc_ex / pc_plus_4_ex  in  32 each  instruction PC and PC+4
rd_ex / func_3_ex / func_7_bit_6_ex  in  5/3/1  decode fields
im_to_rf_ex / store_ex / load_ex / branch_ex  in  1 each  control bits
alu_operand_a_selector_ex  in  2  00 rs1, 01 pc, 10 zero, 11 zero
alu_operand_b_selector_ex  in  1  0 rs2, 1 immediate_ex
next_pc_selector_ex  in  2  00 seq, 01 branch, 10 jal, 11 jalr
alu_operations_selector_ex  in  2  00 add, 01 R-type, 10 I-type, 11 branch compare
rs1_data_ex / rs2_data_ex / i_type_ex / sb_type_ex / uj_type_ex / immediate_ex  in  32 each  operands and immediates
alu_result_mem / rs2_data_mem  out  32 each  registered ALU (or link) result and forwarded store data
rd_mem / func_3_mem  out  5/3  registered fields
im_to_rf_mem / store_mem / load_mem / valid_mem  out  1 each  registered control bits
redirect  out  1  combinational; PC redirect this cycle
redirect_pc  out  32  combinational target
misaligned  out  1  combinational; redirect target bit 1 is set

Behaviour:
Reset and registered outputs:
- Reset (rst=1 at a posedge) clears every EX/MEM output and the redirect_done flag to 0.
- Reset takes priority over flush, and flush takes priority over stall.
- Mid-operation reset discards the in-flight result; no redirect is issued in that cycle because redirect is gated by !rst.
- Latency: EX/MEM outputs update 1 cycle after EX inputs when stall=0.
- Flush writes valid_mem=0 and all control bits 0; data fields are don't-care and are zeroed.
- Stall holds all EX/MEM registers.
- With valid_ex=0, the stage registers a bubble exactly as flush does.

Operands and ALU:
- Operand A = forwarded rs1 / pc / 0 per the selector.
- Operand B = forwarded rs2 or immediate_ex.
- Store data = forwarded rs2.
- ALU op 00: A+B.
- ALU op 01: func_3 decode; func_7_bit_6 selects SUB (000) and SRA (101).
- ALU op 10: same as 01, except func_7_bit_6 is honoured only for func_3=101 (SRAI); ADDI never subtracts.
- Shift amounts use B[4:0]. SLT is signed; SLTU is unsigned.
- ALU op 11 (compare on func_3): 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken.
- For jal/jalr, alu_result = pc_plus_4_ex (link value).

Redirect:
- Taken = (sel=01 & branch_ex & cmp) | sel=10 | sel=11.
- Targets: branch pc_ex+sb_type_ex; jal pc_ex+uj_type_ex; jalr (fwdA+i_type_ex)&RESET_PC_MASK. All sums wrap modulo 2^32.
- redirect = valid_ex & taken & !redirect_done & !rst.

redirect_done FSM (states IDLE, DONE):
- IDLE→DONE when redirect=1 and stall=1.
- DONE→IDLE when stall=0, or on flush or reset.
- Guarantees one redirect pulse per instruction across a multi-cycle stall.
- redirect and flush in the same cycle is legal: the redirect is still reported.

Misaligned jump:
- misaligned = redirect & redirect_pc[1].
- The target is still output; trapping is out of scope.

Decomposition:
- Package ex_pkg: enums for the alu operand A selector, next pc selector, alu operations selector and forward selector.
- Package ex_pkg: func_3 localparams for ALU and branch ops.
- Package ex_pkg: a packed struct for the EX/MEM bundle.
- One sub-module, alu_core: combinational ALU plus comparator (A, B, op, func_3, func_7_bit_6 → result, cmp).
- Forwarding muxes, redirect logic, FSM and register stay in ex_stage.

Test Plan:
- ADD/SUB: rs1=7, rs2=3, R-type, func_3=000, bit6=0 → alu_result_mem=10 after 1 clk; repeat with bit6=1 → 4; ADDI with bit6=1, imm=3 → 10.
- Forwarding: forward_a_sel=01 with alu_result_mem=0x100, forward_b_sel=10 with wb_data=5, ADD → 0x105; rs2_data_mem=5 on a store.
- BLT signed: fwd rs1=0xFFFFFFFF, rs2=1, pc=0x40, sb=0x10 → redirect=1, redirect_pc=0x50; same operands with BLTU → redirect=0.
- JALR: rs1=0x1003, i_type=0 → redirect_pc=0x1002, misaligned=1, alu_result_mem=pc_plus_4_ex.
- Branch taken with stall held 3 cycles → redirect high only in the first cycle; EX/MEM held; a new taken branch after release redirects again.
- Reset mid-stall with a taken jump → outputs 0 next edge, redirect=0 during reset; flush+stall together → valid_mem=0.
